// File: rtl/alu_dispatch.sv
// alu_dispatch: front-end stage of the ALU.
//   Takes one operation from decode (in_valid/in_ready) and decodes funct3/alt
//   into decryptedOP. It then presents registered operands to the functional
//   units with dat_ready for one ISSUE cycle plus LATENCY WAIT cycles. The unit
//   result and flags are captured on the edge that ends the last WAIT cycle.
//   The captured result is then held for writeback (out_valid/out_ready).
// Ports:
//   soc_clk, reset (async, active low), flush (sync abort)
//   in_*          : decode handshake, funct3, alt bit, operands
//   ALU_*, decryptedOP, dat_ready : registered operands/op to the units
//   unit_*        : selected unit result, carry/overflow, zero
//   out_*         : captured result/flags to writeback handshake
module alu_dispatch #(
   parameter int unsigned LATENCY = 1,
   parameter int unsigned WIDTH   = 32
) (
   input  logic             soc_clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_opcode,
   input  logic             in_alt,
   input  logic [WIDTH-1:0] in_dat1,
   input  logic [WIDTH-1:0] in_dat2,
   output logic [WIDTH-1:0] ALU_dat1,
   output logic [WIDTH-1:0] ALU_dat2,
   output logic [2:0]       ALU_opcode,
   output logic [3:0]       decryptedOP,
   output logic             dat_ready,
   input  logic [WIDTH-1:0] unit_result,
   input  logic             unit_overflow,
   input  logic             unit_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_overflow,
   output logic             out_zero,
   output logic             out_illegal
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] dat1_q, dat1_d, dat2_q, dat2_d;
   logic [2:0]       opc_q, opc_d;
   logic [3:0]       dop_q, dop_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             ovf_q, ovf_d, zero_q, zero_d, ill_q, ill_d;

   logic [3:0]       dec_op;
   logic             dec_ill;

   // funct3/alt decode; only ADD/SUB and SRL/SRA use the alt bit.
   always_comb begin
      dec_op  = 4'd0;
      dec_ill = 1'b0;
      case (in_opcode)
         3'b000: dec_op = in_alt ? 4'd7 : 4'd6;
         3'b001: dec_op = 4'd8;
         3'b010: dec_op = 4'd9;
         3'b011: dec_op = 4'd10;
         3'b100: dec_op = 4'd1;
         3'b101: dec_op = in_alt ? 4'd12 : 4'd11;
         3'b110: dec_op = 4'd2;
         default: dec_op = 4'd3;
      endcase
      if (in_alt && (in_opcode != 3'b000) && (in_opcode != 3'b101)) begin
         dec_ill = 1'b1;
         dec_op  = 4'd0;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dat1_d  = dat1_q;
      dat2_d  = dat2_q;
      opc_d   = opc_q;
      dop_d   = dop_q;
      res_d   = res_q;
      ovf_d   = ovf_q;
      zero_d  = zero_q;
      ill_d   = ill_q;
      if (flush) begin
         // Abort anything in flight; captured out_* values are left alone.
         state_d = S_IDLE;
         cnt_d   = 4'd0;
         dat1_d  = '0;
         dat2_d  = '0;
         dop_d   = 4'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  opc_d = in_opcode;
                  if (dec_ill) begin
                     // Illegal ops bypass the units and complete immediately.
                     state_d = S_DONE;
                     dat1_d  = '0;
                     dat2_d  = '0;
                     dop_d   = 4'd0;
                     res_d   = '0;
                     ovf_d   = 1'b0;
                     zero_d  = 1'b1;
                     ill_d   = 1'b1;
                  end else begin
                     state_d = S_ISSUE;
                     dat1_d  = in_dat1;
                     dat2_d  = in_dat2;
                     dop_d   = dec_op;
                  end
               end
            end
            S_ISSUE: begin
               cnt_d   = 4'(LATENCY);
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (cnt_q == 4'd1) begin
                  res_d   = unit_result;
                  ovf_d   = unit_overflow;
                  zero_d  = unit_zero;
                  ill_d   = 1'b0;
                  cnt_d   = 4'd0;
                  dat1_d  = '0;
                  dat2_d  = '0;
                  dop_d   = 4'd0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            default: begin
               if (out_ready) state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge soc_clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         dat1_q  <= '0;
         dat2_q  <= '0;
         opc_q   <= 3'd0;
         dop_q   <= 4'd0;
         res_q   <= '0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dat1_q  <= dat1_d;
         dat2_q  <= dat2_d;
         opc_q   <= opc_d;
         dop_q   <= dop_d;
         res_q   <= res_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         ill_q   <= ill_d;
      end
   end

   assign in_ready     = (state_q == S_IDLE);
   assign dat_ready    = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign out_valid    = (state_q == S_DONE);
   assign ALU_dat1     = dat1_q;
   assign ALU_dat2     = dat2_q;
   assign ALU_opcode   = opc_q;
   assign decryptedOP  = dop_q;
   assign out_result   = res_q;
   assign out_overflow = ovf_q;
   assign out_zero     = zero_q;
   assign out_illegal  = ill_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: instance 0 uses LATENCY=1 and instance 1 uses LATENCY=3.
// A stub unit per instance returns a correct result only in the final WAIT cycle.
// In every other cycle it returns a poison value.
module tb_alu_dispatch;

   typedef struct {
      int          dut;
      logic [31:0] res;
      logic        ovf;
      logic        zero;
      logic        ill;
   } exp_t;

   logic clk, rst_n, flush;
   logic [1:0]       iv, alt, ordy, irdy, drdy, ov, oovf, ozero, oill, uovf, uzero;
   logic [1:0][2:0]  iop, aop;
   logic [1:0][3:0]  dop;
   logic [1:0][31:0] d1, d2, ad1, ad2, ores, ures;
   int ucnt [2];

   exp_t sbq[$];
   int checks = 0;
   int failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int unsigned L = (k == 0) ? 1 : 3;
      alu_dispatch #(.LATENCY(L), .WIDTH(32)) u_dut (
         .soc_clk(clk), .reset(rst_n), .flush(flush),
         .in_valid(iv[k]), .in_ready(irdy[k]), .in_opcode(iop[k]), .in_alt(alt[k]),
         .in_dat1(d1[k]), .in_dat2(d2[k]),
         .ALU_dat1(ad1[k]), .ALU_dat2(ad2[k]), .ALU_opcode(aop[k]),
         .decryptedOP(dop[k]), .dat_ready(drdy[k]),
         .unit_result(ures[k]), .unit_overflow(uovf[k]), .unit_zero(uzero[k]),
         .out_valid(ov[k]), .out_ready(ordy[k]), .out_result(ores[k]),
         .out_overflow(oovf[k]), .out_zero(ozero[k]), .out_illegal(oill[k])
      );
   end

   // Counts dat_ready cycles already completed in the current burst.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) ucnt[k] <= drdy[k] ? ucnt[k] + 1 : 0;
   end

   // Stub functional unit.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         ures[k]  = 32'hDEADBEEF;
         uovf[k]  = 1'b1;
         uzero[k] = 1'b0;
         if (drdy[k] && ucnt[k] == ((k == 0) ? 1 : 3)) begin
            uovf[k] = 1'b0;
            case (dop[k])
               4'd6:  {uovf[k], ures[k]} = {1'b0, ad1[k]} + {1'b0, ad2[k]};
               4'd7:  begin ures[k] = ad1[k] - ad2[k]; uovf[k] = ad1[k] < ad2[k]; end
               4'd1:  ures[k] = ad1[k] ^ ad2[k];
               4'd2:  ures[k] = ad1[k] | ad2[k];
               4'd3:  ures[k] = ad1[k] & ad2[k];
               4'd8:  ures[k] = ad1[k] << ad2[k][4:0];
               4'd9:  ures[k] = {31'd0, $signed(ad1[k]) < $signed(ad2[k])};
               4'd10: ures[k] = {31'd0, ad1[k] < ad2[k]};
               4'd11: ures[k] = ad1[k] >> ad2[k][4:0];
               4'd12: ures[k] = $unsigned($signed(ad1[k]) >>> ad2[k][4:0]);
               default: ures[k] = 32'hBAD0BAD0;
            endcase
            uzero[k] = (ures[k] == 32'd0);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: compares at every writeback handshake.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst_n && ov[k] && ordy[k]) begin
            if (sbq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: dut %0d result %h with empty scoreboard", k, ores[k]);
            end else begin
               exp_t e;
               e = sbq.pop_front();
               chk("sb_dut", k, e.dut);
               chk("sb_result", ores[k], e.res);
               chk("sb_overflow", {31'd0, oovf[k]}, {31'd0, e.ovf});
               chk("sb_zero", {31'd0, ozero[k]}, {31'd0, e.zero});
               chk("sb_illegal", {31'd0, oill[k]}, {31'd0, e.ill});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int k, input logic [2:0] op, input logic a,
                        input logic [31:0] x, input logic [31:0] y);
      int n = 0;
      while (!irdy[k] && n < 40) begin step(); n++; end
      chk("issue_in_ready", {31'd0, irdy[k]}, 32'd1);
      iv[k] = 1'b1; iop[k] = op; alt[k] = a; d1[k] = x; d2[k] = y;
      step();
      iv[k] = 1'b0;
   endtask

   task automatic run(input int k, input logic [2:0] op, input logic a,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] er, input logic eo, input logic ez,
                      input logic ei, input logic [3:0] edop, input int hold);
      int cyc = 0;
      int dr = 0;
      bit seen = 0;
      int ecyc = ei ? 0 : ((k == 0) ? 2 : 4);
      sbq.push_back('{k, er, eo, ez, ei});
      ordy[k] = 1'b0;
      issue(k, op, a, x, y);
      while (!ov[k] && cyc < 40) begin
         if (drdy[k]) begin
            dr++;
            if (!seen) begin chk("decryptedOP", {28'd0, dop[k]}, {28'd0, edop}); seen = 1; end
         end
         step();
         cyc++;
      end
      chk("latency", cyc, ecyc);
      chk("dat_ready_cycles", dr, ecyc);
      chk("done_in_ready", {31'd0, irdy[k]}, 32'd0);
      chk("done_dat1_clear", ad1[k], 32'd0);
      chk("done_decop_clear", {28'd0, dop[k]}, 32'd0);
      for (int i = 0; i < hold; i++) begin
         step();
         chk("hold_stable", {ov[k], irdy[k], oovf[k], ozero[k], ores[k][27:0]},
             {1'b1, 1'b0, eo, ez, er[27:0]});
      end
      ordy[k] = 1'b1;
      step();
      ordy[k] = 1'b0;
      chk("out_valid_drop", {31'd0, ov[k]}, 32'd0);
      chk("result_kept", ores[k], er);
   endtask

   initial begin
      int c;
      rst_n = 1'b0; flush = 1'b0;
      iv = '0; alt = '0; ordy = '0; iop = '0; d1 = '0; d2 = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_in_ready", {31'd0, irdy[0]}, 32'd1);
      chk("rst_out", {ov[0], drdy[0], oill[0], ozero[0], dop[0]}, 8'd0);
      chk("rst_regs", ores[0] | ad1[0] | ad2[0], 32'd0);

      //   k op      alt x             y             result        ovf  zero ill  dop hold
      run(0, 3'b000, 0, 32'd5,        32'd7,        32'd12,        0,   0,   0,   6,  0);
      run(0, 3'b000, 1, 32'h1234,     32'h1234,     32'd0,         0,   1,   0,   7,  0);
      run(0, 3'b000, 0, 32'hFFFFFFFF, 32'd1,        32'd0,         1,   1,   0,   6,  10);
      run(0, 3'b110, 1, 32'h55,       32'h66,       32'd0,         0,   1,   1,   0,  0);
      run(0, 3'b101, 1, 32'h80000000, 32'd4,        32'hF8000000,  0,   0,   0,   12, 0);
      run(0, 3'b101, 0, 32'h80000000, 32'd4,        32'h08000000,  0,   0,   0,   11, 0);
      run(0, 3'b011, 0, 32'd1,        32'd2,        32'd1,         0,   0,   0,   10, 0);
      run(0, 3'b001, 0, 32'd1,        32'd31,       32'h80000000,  0,   0,   0,   8,  0);
      run(0, 3'b100, 0, 32'hF0F0,     32'hFF00,     32'h0FF0,      0,   0,   0,   1,  0);
      run(0, 3'b111, 0, 32'hF0F0,     32'hFF00,     32'hF000,      0,   0,   0,   3,  0);
      run(0, 3'b010, 0, 32'hFFFFFFFF, 32'd1,        32'd1,         0,   0,   0,   9,  0);

      // Flush while in WAIT discards the operation.
      issue(0, 3'b000, 0, 32'd1, 32'd2);
      step();
      chk("pre_flush_wait", {31'd0, drdy[0]}, 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_state", {irdy[0], drdy[0], ov[0], dop[0]}, {1'b1, 1'b0, 1'b0, 4'd0});
      ordy[0] = 1'b1;
      repeat (3) step();
      chk("flush_no_output", {31'd0, ov[0]}, 32'd0);
      ordy[0] = 1'b0;
      // Flush beats in_valid in IDLE.
      iv[0] = 1'b1; iop[0] = 3'b000; alt[0] = 1'b0; flush = 1'b1;
      step();
      iv[0] = 1'b0; flush = 1'b0;
      chk("flush_no_accept", {irdy[0], drdy[0]}, 2'b10);

      // Asynchronous reset in the middle of WAIT.
      issue(0, 3'b000, 0, 32'd9, 32'd9);
      step();
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_out", {drdy[0], ov[0], oill[0], oovf[0], ozero[0], dop[0]}, 9'd0);
      chk("async_rst_regs", ores[0] | ad1[0] | ad2[0], 32'd0);
      @(negedge clk) rst_n = 1'b1;
      step();
      chk("post_rst_ready", {irdy[0], ov[0]}, 2'b10);

      // LATENCY=3 instance, single op then back-to-back ops completed in order.
      run(1, 3'b000, 0, 32'd100, 32'd23, 32'd123, 0, 0, 0, 6, 0);
      ordy[1] = 1'b1;
      sbq.push_back('{1, 32'd77, 1'b0, 1'b0, 1'b0});
      sbq.push_back('{1, 32'd42, 1'b0, 1'b0, 1'b0});
      issue(1, 3'b000, 0, 32'd70, 32'd7);
      iv[1] = 1'b1; iop[1] = 3'b000; alt[1] = 1'b1; d1[1] = 32'd50; d2[1] = 32'd8;
      c = 1;
      while (!irdy[1] && c < 40) begin step(); c++; end
      chk("accept_to_accept", c, 32'd6);
      step();
      iv[1] = 1'b0;
      c = 0;
      while (!ov[1] && c < 40) begin step(); c++; end
      chk("second_op_latency", c, 32'd4);
      step();
      ordy[1] = 1'b0;

      repeat (4) step();
      chk("scoreboard_empty", sbq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
